// File: rtl/mdu_sched.sv
// mdu_sched: multiply/divide sequencer for the 5-stage MIPS pipeline; owns HI/LO.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   E_valid         - E-stage instruction is real
//   E_md_op         - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   E_mf_sel        - 1 mfhi, 2 mflo, otherwise none
//   E_rs, E_rt      - forwarded operands in E
//   D_uses_md       - D-stage instruction touches the MDU
//   busy, stall     - MDU occupied / hold F/D and bubble D/E
//   E_MDUAns        - mfhi/mflo read data
//   HI, LO          - architectural HI/LO
module mdu_sched #(
  parameter int unsigned MUL_CYC = 5,
  parameter int unsigned DIV_CYC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_valid,
  input  logic [2:0]  E_md_op,
  input  logic [1:0]  E_mf_sel,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] E_MDUAns,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic        div0_q, div0_d;

  logic        idle, is_mul, is_div, is_signed, start;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] abs_a, abs_b, divisor, uq, ur, quo, rem;
  logic        q_neg, r_neg;

  always_comb begin
    idle      = (state_q == IDLE);
    is_mul    = (E_md_op == 3'd1) || (E_md_op == 3'd2);
    is_div    = (E_md_op == 3'd3) || (E_md_op == 3'd4);
    is_signed = (E_md_op == 3'd1) || (E_md_op == 3'd3);
    start     = E_valid && idle && (is_mul || is_div);

    // Sign/zero-extend to 64 bits; the low 64 bits of the product are exact either way.
    mul_a = is_signed ? {{32{E_rs[31]}}, E_rs} : {32'b0, E_rs};
    mul_b = is_signed ? {{32{E_rt[31]}}, E_rt} : {32'b0, E_rt};
    prod  = mul_a * mul_b;

    // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000, rem 0.
    abs_a   = (is_signed && E_rs[31]) ? -E_rs : E_rs;
    abs_b   = (is_signed && E_rt[31]) ? -E_rt : E_rt;
    divisor = (E_rt == 32'd0) ? 32'd1 : abs_b;
    uq      = abs_a / divisor;
    ur      = abs_a % divisor;
    q_neg   = is_signed && (E_rs[31] ^ E_rt[31]);
    r_neg   = is_signed && E_rs[31];
    quo     = q_neg ? -uq : uq;
    rem     = r_neg ? -ur : ur;

    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    div0_d   = div0_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul) begin
            state_d  = RUN_MUL;
            cnt_d    = 4'(MUL_CYC);
            res_hi_d = prod[63:32];
            res_lo_d = prod[31:0];
            div0_d   = 1'b0;
          end else begin
            state_d  = RUN_DIV;
            cnt_d    = 4'(DIV_CYC);
            res_hi_d = rem;
            res_lo_d = quo;
            div0_d   = (E_rt == 32'd0);
          end
        end else if (E_valid && E_md_op == 3'd5) begin
          hi_d = E_rs;
        end else if (E_valid && E_md_op == 3'd6) begin
          lo_d = E_rs;
        end
      end
      default: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (!div0_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      div0_q   <= div0_d;
    end
  end

  always_comb begin
    busy  = start || !idle;
    stall = D_uses_md && busy;
    case (E_mf_sel)
      2'd1:    E_MDUAns = hi_q;
      2'd2:    E_MDUAns = lo_q;
      default: E_MDUAns = '0;
    endcase
    HI = hi_q;
    LO = lo_q;
  end

endmodule
